noc_flit_sink: RTL and testbench

//  Ejection-side endpoint of the mesh NoC. Receives flits from a router local output port
//  (sender_* side of a node) over valid/ready, strips and checks the header flit, and streams

---
 rtl/noc_flit_sink.sv | 191 +++++++++++++++++++
 tb/tb_noc_flit_sink.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_sink.sv
// noc_flit_sink
//   Ejection-side endpoint of the mesh NoC. Accepts flits from a router local
//   output port, strips and checks the header flit, and streams the payload
//   words to a local consumer through a single output register. It counts
//   delivered packets and flags framing, routing and length errors.
//
//   Optional feature macro: NOC_SINK_DROP_MISROUTE_EN
//     defined     : a misrouted packet is swallowed in DROP and never reaches out_*
//     not defined : err_route still pulses, but the packet is delivered normally
//
// Ports
//   noc_clk, noc_rst        clock, asynchronous active-high reset
//   in_valid/in_ready       flit handshake from the router ejection port
//   in_flit                 flit data
//   in_is_header/in_is_tail flit framing (a flit may be both header and tail)
//   out_valid/out_ready     payload word handshake towards the consumer
//   out_data, out_last      payload word, and whether it came from the tail flit
//   out_src_x, out_src_y    source coordinates of the packet carrying out_data
//   pkt_cnt                 completed packets, saturating at 8'hFF
//   err_proto/route/len     single-cycle error pulses, registered
module noc_flit_sink #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_is_header,
  input  logic              in_is_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ID_W-1:0]   out_src_x,
  output logic [ID_W-1:0]   out_src_y,
  output logic [7:0]        pkt_cnt,
  output logic              err_proto,
  output logic              err_route,
  output logic              err_len
);

`ifdef NOC_SINK_DROP_MISROUTE_EN
  localparam bit DROP_MISROUTE = 1'b1;
`else
  localparam bit DROP_MISROUTE = 1'b0;
`endif

  localparam logic [ID_W-1:0] MY_X = ID_W'(X_ID);
  localparam logic [ID_W-1:0] MY_Y = ID_W'(Y_ID);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] cur_src_x, cur_src_y;
  logic [7:0]      cur_len;
  logic [7:0]      beat_cnt;
  // Set only when DROP was entered for a misrouted packet; such a packet still
  // counts as completed at its tail, whereas a framing-error drop does not.
  logic            drop_counts;

  logic [ID_W-1:0] hdr_dst_x, hdr_dst_y, hdr_src_x, hdr_src_y;
  logic [7:0]      hdr_len;
  logic            misroute;
  logic            accept;
  logic            load;
  logic            latch_hdr;
  logic            clear_drop;
  logic            inc_pkt;
  logic            e_proto, e_route, e_len;

  assign hdr_dst_x = in_flit[ID_W-1:0];
  assign hdr_dst_y = in_flit[2*ID_W-1:ID_W];
  assign hdr_src_x = in_flit[3*ID_W-1:2*ID_W];
  assign hdr_src_y = in_flit[4*ID_W-1:3*ID_W];
  assign hdr_len   = in_flit[4*ID_W+7:4*ID_W];
  assign misroute  = (hdr_dst_x != MY_X) || (hdr_dst_y != MY_Y);

  // Only BODY forwards into the output register, so only BODY needs backpressure.
  assign in_ready = (state != BODY) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    latch_hdr  = 1'b0;
    clear_drop = 1'b0;
    inc_pkt    = 1'b0;
    e_proto    = 1'b0;
    e_route    = 1'b0;
    e_len      = 1'b0;
    if (accept) begin
      if (in_is_header) begin
        // A header is handled identically in every state; outside IDLE it also
        // abandons whatever packet was in progress.
        e_proto = (state != IDLE);
        e_route = misroute;
        if (in_is_tail) begin
          inc_pkt = 1'b1;
          e_len   = (hdr_len != 8'd0);
          state_n = IDLE;
        end else begin
          latch_hdr = 1'b1;
          state_n   = (DROP_MISROUTE && misroute) ? DROP : BODY;
        end
      end else begin
        unique case (state)
          IDLE: begin
            e_proto    = 1'b1;
            clear_drop = 1'b1;
            state_n    = in_is_tail ? IDLE : DROP;
          end
          BODY: begin
            load = 1'b1;
            if (in_is_tail) begin
              inc_pkt = 1'b1;
              e_len   = ((beat_cnt + 8'd1) != cur_len);
              state_n = IDLE;
            end
          end
          DROP: begin
            if (in_is_tail) begin
              inc_pkt = drop_counts;
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state       <= IDLE;
      cur_src_x   <= '0;
      cur_src_y   <= '0;
      cur_len     <= '0;
      beat_cnt    <= '0;
      drop_counts <= 1'b0;
    end else begin
      state <= state_n;
      if (latch_hdr) begin
        cur_src_x   <= hdr_src_x;
        cur_src_y   <= hdr_src_y;
        cur_len     <= hdr_len;
        beat_cnt    <= '0;
        drop_counts <= misroute;
      end else begin
        if (clear_drop) drop_counts <= 1'b0;
        if (load)       beat_cnt    <= beat_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src_x <= '0;
      out_src_y <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_flit;
      out_last  <= in_is_tail;
      out_src_x <= cur_src_x;
      out_src_y <= cur_src_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_cnt   <= '0;
      err_proto <= 1'b0;
      err_route <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      if (inc_pkt && (pkt_cnt != 8'hFF)) pkt_cnt <= pkt_cnt + 8'd1;
      err_proto <= e_proto;
      err_route <= e_route;
      err_len   <= e_len;
    end
  end

endmodule

// File: tb/tb_noc_flit_sink.sv
// Bench for noc_flit_sink with X_ID=1, Y_ID=1. Directed packets push their
// expected payload words and error pulses into queues; a monitor pops and
// compares on each output handshake and on each error pulse.
module tb_noc_flit_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_flit = '0;
  logic        in_is_header = 1'b0;
  logic        in_is_tail = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  out_src_x, out_src_y;
  logic [7:0]  pkt_cnt;
  logic        err_proto, err_route, err_len;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  sx;
    logic [3:0]  sy;
  } word_t;

  word_t      exp_q[$];
  logic [2:0] err_q[$];   // {proto, route, len}
  int         checks = 0;
  int         errors = 0;

  noc_flit_sink #(.DATA_W(32), .ID_W(4), .X_ID(1), .Y_ID(1)) dut (
    .noc_clk(clk), .noc_rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src_x(out_src_x), .out_src_y(out_src_y),
    .pkt_cnt(pkt_cnt), .err_proto(err_proto), .err_route(err_route), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all bench inputs change #1 after the rising edge, so the
  // falling edge sees exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_word: unexpected word %h, none expected", out_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(w.data));
          check("out_last", 64'(out_last), 64'(w.last));
          check("out_src", 64'({out_src_x, out_src_y}), 64'({w.sx, w.sy}));
        end
      end
      if (err_proto || err_route || err_len) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_pulse: unexpected %b, none expected", {err_proto, err_route, err_len});
        end else begin
          check("err_pulse", 64'({err_proto, err_route, err_len}), 64'(err_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic h, input logic t);
    int unsigned n = 0;
    bit done = 0;
    in_valid = 1'b1; in_flit = d; in_is_header = h; in_is_tail = t;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (++n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, flit %h", n, d);
        done = 1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_header = 1'b0; in_is_tail = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l, input logic [3:0] sx, input logic [3:0] sy);
    word_t w;
    w.data = d; w.last = l; w.sx = sx; w.sy = sy;
    exp_q.push_back(w);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_errs", 64'({err_proto, err_route, err_len}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(1);

    // Basic 3-flit packet, full throughput
    push_word(32'hA000_0001, 1'b0, 4'd0, 4'd0);
    push_word(32'hB000_0002, 1'b0, 4'd0, 4'd0);
    push_word(32'hC000_0003, 1'b1, 4'd0, 4'd0);
    send(32'h0003_0011, 1'b1, 1'b0);
    send(32'hA000_0001, 1'b0, 1'b0);
    send(32'hB000_0002, 1'b0, 1'b0);
    send(32'hC000_0003, 1'b0, 1'b1);
    idle(3);
    check("pkt_cnt_t1", 64'(pkt_cnt), 64'd1);

    // Same packet with consumer stalled after the first word
    push_word(32'hA100_0011, 1'b0, 4'd0, 4'd0);
    push_word(32'hB100_0012, 1'b0, 4'd0, 4'd0);
    push_word(32'hC100_0013, 1'b1, 4'd0, 4'd0);
    send(32'h0003_0011, 1'b1, 1'b0);
    out_ready = 1'b0;
    send(32'hA100_0011, 1'b0, 1'b0);
    in_valid = 1'b1; in_flit = 32'hB100_0012;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_data", 64'(out_data), 64'hA100_0011);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hB100_0012, 1'b0, 1'b0);
    send(32'hC100_0013, 1'b0, 1'b1);
    idle(3);
    check("pkt_cnt_t2", 64'(pkt_cnt), 64'd2);

    // Zero-payload packets: LEN=0 clean, LEN=2 length error
    send(32'h0000_0011, 1'b1, 1'b1);
    err_q.push_back(3'b001);
    send(32'h0002_0011, 1'b1, 1'b1);
    idle(3);
    check("pkt_cnt_t3", 64'(pkt_cnt), 64'd4);

    // Misrouted packet to (2,2)
    err_q.push_back(3'b010);
`ifndef NOC_SINK_DROP_MISROUTE_EN
    push_word(32'hD000_0004, 1'b0, 4'd0, 4'd0);
    push_word(32'hE000_0005, 1'b1, 4'd0, 4'd0);
`endif
    send(32'h0002_0022, 1'b1, 1'b0);
    send(32'hD000_0004, 1'b0, 1'b0);
    send(32'hE000_0005, 1'b0, 1'b1);
    idle(3);
    check("pkt_cnt_t4", 64'(pkt_cnt), 64'd5);

    // Body flits while idle: discarded, never counted
    err_q.push_back(3'b100);
    send(32'h0000_0055, 1'b0, 1'b1);
    err_q.push_back(3'b100);
    send(32'h0000_0066, 1'b0, 1'b0);
    send(32'h0000_0077, 1'b0, 1'b1);
    idle(3);
    check("pkt_cnt_t5a", 64'(pkt_cnt), 64'd5);

    // Header mid-body abandons the old packet, new one delivered with its src
    push_word(32'hF000_0006, 1'b0, 4'd0, 4'd0);
    push_word(32'h6000_0007, 1'b1, 4'd3, 4'd2);
    send(32'h0002_0011, 1'b1, 1'b0);
    send(32'hF000_0006, 1'b0, 1'b0);
    err_q.push_back(3'b100);
    send(32'h0001_2311, 1'b1, 1'b0);
    send(32'h6000_0007, 1'b0, 1'b1);
    idle(3);
    check("pkt_cnt_t5b", 64'(pkt_cnt), 64'd6);

    // LEN=3 but tail on the second flit
    push_word(32'h1000_0008, 1'b0, 4'd0, 4'd0);
    push_word(32'h1000_0009, 1'b1, 4'd0, 4'd0);
    err_q.push_back(3'b001);
    send(32'h0003_0011, 1'b1, 1'b0);
    send(32'h1000_0008, 1'b0, 1'b0);
    send(32'h1000_0009, 1'b0, 1'b1);
    idle(3);
    check("pkt_cnt_t6", 64'(pkt_cnt), 64'd7);

    // Reset with a word parked in the output register
    out_ready = 1'b0;
    send(32'h0003_0011, 1'b1, 1'b0);
    send(32'h2000_000A, 1'b0, 1'b0);
    #2; rst = 1'b1; #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_last_src", 64'({out_last, out_src_x, out_src_y}), 64'd0);
    check("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    send(32'h0000_0011, 1'b1, 1'b1);
    idle(5);
    check("pkt_cnt_after_rst", 64'(pkt_cnt), 64'd1);
    check("words_left", 64'(exp_q.size()), 64'd0);
    check("errs_left", 64'(err_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
